icb_ext_sram_slave: RTL and testbench

ICB_EXT_SRAM_SLAVE -- requirements
Module: icb_ext_sram_slave

---
 rtl/icb_ext_sram_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_icb_ext_sram_slave.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_ext_sram_slave.sv
// ============================================================================
// icb_ext_sram_slave
//
// Word-organised SRAM slave on an ICB-style bus with burst commands.
// A command carries a start byte address, a read/write flag and a length
// (beats = len + 1). Reads return one response per beat, one cycle after the
// command handshake and then one beat per cycle at full rate. Writes accept
// len + 1 write beats and return a single response whose error bit is the OR
// of all out-of-range beats in the burst.
//
// Bus bundles are carried as packed vectors with fixed field layouts:
//   icb_cmd_m  [ADDR_WIDTH+4:0]       = {valid, addr[ADDR_WIDTH-1:0], read, len[2:0]}
//   icb_cmd_s  [0:0]                  = ready
//   icb_wr_m   [DATA_WIDTH+BYTES:0]   = {w_valid, wdata[DATA_WIDTH-1:0], wmask[BYTES-1:0]}
//   icb_wr_s   [0:0]                  = w_ready
//   icb_rsp_s  [DATA_WIDTH+1:0]       = {rsp_valid, rsp_rdata[DATA_WIDTH-1:0], rsp_err}
//   icb_rsp_m  [0:0]                  = rsp_ready
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where both valid and ready are 1. The slave's ready/valid outputs are pure
// registers, so they never depend combinationally on any input; a valid
// response is held unchanged until it is accepted.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   icb_cmd_m    command from master          icb_cmd_s   command ready
//   icb_wr_m     write beat from master       icb_wr_s    write-beat ready
//   icb_rsp_s    response to master           icb_rsp_m   response ready
//   o_dbg_state  current FSM state (0 IDLE, 1 RD_BEAT, 2 WR_BEAT, 3 WR_RSP)
// ============================================================================
module icb_ext_sram_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH+4:0]          icb_cmd_m,
    output logic                           icb_cmd_s,
    input  logic [DATA_WIDTH+DATA_WIDTH/8:0] icb_wr_m,
    output logic                           icb_wr_s,
    output logic [DATA_WIDTH+1:0]          icb_rsp_s,
    input  logic                           icb_rsp_m,
    output logic [1:0]                     o_dbg_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   LP_SPAN  = (ADDR_WIDTH+1)'(DEPTH * BYTES);
    localparam logic [ADDR_WIDTH-1:0] LP_ALIGN = ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_BEAT = 2'd1,
        ST_WR_BEAT = 2'd2,
        ST_WR_RSP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_w_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_len;
    logic [2:0]            r_beat;
    logic                  r_err_sticky;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Field extraction from the packed bundles
    logic                  w_cmd_valid;
    logic [ADDR_WIDTH-1:0] w_cmd_addr;
    logic                  w_cmd_read;
    logic [2:0]            w_cmd_len;
    logic                  w_w_valid;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BYTES-1:0]      w_wmask;
    logic                  w_rsp_ready;

    assign w_cmd_valid = icb_cmd_m[ADDR_WIDTH+4];
    assign w_cmd_addr  = icb_cmd_m[ADDR_WIDTH+3:4];
    assign w_cmd_read  = icb_cmd_m[3];
    assign w_cmd_len   = icb_cmd_m[2:0];
    assign w_w_valid   = icb_wr_m[DATA_WIDTH+BYTES];
    assign w_wdata     = icb_wr_m[DATA_WIDTH+BYTES-1:BYTES];
    assign w_wmask     = icb_wr_m[BYTES-1:0];
    assign w_rsp_ready = icb_rsp_m;

    // In range: word aligned and inside [BASE_ADDR, BASE_ADDR + DEPTH*BYTES).
    // The upper bound is tested on the offset so it cannot overflow.
    function automatic logic f_hit(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return ((a & LP_ALIGN) == '0) && (a >= BASE_ADDR) && ({1'b0, off} < LP_SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = (a - BASE_ADDR) >> OFF;
        return IDX_W'(off);
    endfunction

    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic [ADDR_WIDTH-1:0] w_nxt_addr;
    logic [ADDR_WIDTH-1:0] w_lk_addr;
    logic                  w_lk_hit;
    logic [DATA_WIDTH-1:0] w_lk_data;
    logic                  w_wr_hit;
    logic                  w_cmd_hs;
    logic                  w_w_hs;
    logic                  w_rsp_hs;
    logic                  w_wr_en;

    // Address arithmetic wraps modulo 2^ADDR_WIDTH.
    assign w_cur_addr = r_addr + ({{(ADDR_WIDTH-3){1'b0}}, r_beat} << OFF);
    assign w_nxt_addr = r_addr + ({{(ADDR_WIDTH-3){1'b0}}, r_beat + 3'd1} << OFF);

    // Read lookup: the command address when a burst is being accepted,
    // otherwise the address of the beat that follows the current one.
    assign w_lk_addr = (r_state == ST_IDLE) ? w_cmd_addr : w_nxt_addr;
    assign w_lk_hit  = f_hit(w_lk_addr);
    assign w_lk_data = w_lk_hit ? r_mem[f_idx(w_lk_addr)] : '0;
    assign w_wr_hit  = f_hit(w_cur_addr);

    assign w_cmd_hs = w_cmd_valid & r_cmd_ready;
    assign w_w_hs   = w_w_valid & r_w_ready;
    assign w_rsp_hs = r_rsp_valid & w_rsp_ready;
    assign w_wr_en  = rst_n & (r_state == ST_WR_BEAT) & w_w_hs & w_wr_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_w_ready    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_addr       <= '0;
            r_len        <= 3'd0;
            r_beat       <= 3'd0;
            r_err_sticky <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_addr      <= w_cmd_addr;
                        r_len       <= w_cmd_len;
                        r_beat      <= 3'd0;
                        r_cmd_ready <= 1'b0;
                        if (w_cmd_read) begin
                            // First read beat is presented on the next cycle.
                            r_state     <= ST_RD_BEAT;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_lk_data;
                            r_rsp_err   <= ~w_lk_hit;
                        end else begin
                            r_state   <= ST_WR_BEAT;
                            r_w_ready <= 1'b1;
                        end
                    end
                end
                ST_RD_BEAT: begin
                    if (w_rsp_hs) begin
                        if (r_beat == r_len) begin
                            r_state     <= ST_IDLE;
                            r_rsp_valid <= 1'b0;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_beat      <= 3'd0;
                        end else begin
                            r_beat      <= r_beat + 3'd1;
                            r_rsp_rdata <= w_lk_data;
                            r_rsp_err   <= ~w_lk_hit;
                        end
                    end
                end
                ST_WR_BEAT: begin
                    if (w_w_hs) begin
                        if (!w_wr_hit) r_err_sticky <= 1'b1;
                        if (r_beat == r_len) begin
                            // Fold in this beat's error; the sticky update lands too late.
                            r_state     <= ST_WR_RSP;
                            r_w_ready   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= r_err_sticky | ~w_wr_hit;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                end
                ST_WR_RSP: begin
                    if (w_rsp_hs) begin
                        r_state      <= ST_IDLE;
                        r_rsp_valid  <= 1'b0;
                        r_rsp_err    <= 1'b0;
                        r_err_sticky <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_beat       <= 3'd0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage has no reset: contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wmask[b]) r_mem[f_idx(w_cur_addr)][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign icb_cmd_s   = r_cmd_ready;
    assign icb_wr_s    = r_w_ready;
    assign icb_rsp_s   = {r_rsp_valid, r_rsp_rdata, r_rsp_err};
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_icb_ext_sram_slave.sv
// ============================================================================
// tb_icb_ext_sram_slave
//
// Directed bench for icb_ext_sram_slave. Inputs are driven and outputs sampled
// on the falling clock edge. Expected responses ({err, rdata}) are pushed to
// exp_q from a byte-level memory model when a burst is issued and popped when
// the DUT returns the matching response.
// ============================================================================
module tb_icb_ext_sram_slave;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [AW-1:0] cmd_addr;
  logic          cmd_read;
  logic [2:0]    cmd_len;
  logic          w_valid;
  logic [DW-1:0] wdata;
  logic [3:0]    wmask;
  logic          rsp_ready;

  logic [AW+4:0] cmd_m;
  logic          cmd_s;
  logic [DW+4:0] wr_m;
  logic          wr_s;
  logic [DW+1:0] rsp_s;
  logic [1:0]    dbg_state;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  assign cmd_m     = {cmd_valid, cmd_addr, cmd_read, cmd_len};
  assign wr_m      = {w_valid, wdata, wmask};
  assign rsp_valid = rsp_s[DW+1];
  assign rsp_rdata = rsp_s[DW:1];
  assign rsp_err   = rsp_s[0];

  icb_ext_sram_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .icb_cmd_m  (cmd_m),
    .icb_cmd_s  (cmd_s),
    .icb_wr_m   (wr_m),
    .icb_wr_s   (wr_s),
    .icb_rsp_s  (rsp_s),
    .icb_rsp_m  (rsp_ready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [DW:0] exp_q[$];
  logic [31:0] model_mem[DEPTH];
  logic [31:0] wd[8];
  logic [3:0]  wm[8];
  int          gap[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + DEPTH * 4);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_cmd(input logic [31:0] addr, input logic rd, input logic [2:0] len);
    int n;
    cmd_addr  = addr;
    cmd_read  = rd;
    cmd_len   = len;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_s !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 64'(n < 20), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [2:0] len);
    logic        err;
    logic [31:0] a;
    logic [DW:0] e;
    int          n;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 32'(4 * i);
      if (in_rng(a)) begin
        for (int b = 0; b < 4; b++)
          if (wm[i][b]) model_mem[idx_of(a)][8*b +: 8] = wd[i][8*b +: 8];
      end else begin
        err = 1'b1;
      end
    end
    exp_q.push_back({err, 32'h0});
    send_cmd(addr, 1'b0, len);
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b0;
      repeat (gap[i]) @(negedge clk);
      wdata   = wd[i];
      wmask   = wm[i];
      w_valid = 1'b1;
      n = 0;
      while (wr_s !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("wr_ready_wait", 64'(n < 20), 64'd1);
      @(negedge clk);
    end
    w_valid   = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_rsp_wait", 64'(n < 20), 64'd1);
    check("wr_rsp_w_ready_low", 64'(wr_s), 64'd0);
    e = exp_q.pop_front();
    check("wr_rsp_err", 64'(rsp_err), 64'(e[DW]));
    check("wr_rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
    @(negedge clk);
    rsp_ready = 1'b0;
    check("wr_done_rsp_valid", 64'(rsp_valid), 64'd0);
    check("wr_done_cmd_ready", 64'(cmd_s), 64'd1);
  endtask

  // pat[k % patlen] is the rsp_ready value driven on the k-th sampled cycle.
  task automatic read_burst(input logic [31:0] addr, input logic [2:0] len,
                            input logic [15:0] pat, input int patlen);
    logic [31:0] a;
    logic [DW:0] e;
    int          got;
    int          n;
    int          k;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 32'(4 * i);
      if (in_rng(a)) exp_q.push_back({1'b0, model_mem[idx_of(a)]});
      else           exp_q.push_back({1'b1, 32'h0});
    end
    send_cmd(addr, 1'b1, len);
    check("rd_latency", 64'(rsp_valid), 64'd1);
    got = 0;
    n   = 0;
    k   = 0;
    while (got < int'(len) + 1 && n < 200) begin
      rsp_ready = pat[k % patlen];
      k++;
      if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q[0];
        check("rd_cmd_ready_low", 64'(cmd_s), 64'd0);
        check($sformatf("rd_beat%0d_err", got), 64'(rsp_err), 64'(e[DW]));
        check($sformatf("rd_beat%0d_rdata", got), 64'(rsp_rdata), 64'(e[DW-1:0]));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      @(negedge clk);
      n++;
    end
    check("rd_beat_count", 64'(got), 64'(int'(len) + 1));
    rsp_ready = 1'b0;
    check("rd_done_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rd_done_cmd_ready", 64'(cmd_s), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW:0] e;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_read  = 1'b0;
    cmd_len   = 3'd0;
    w_valid   = 1'b0;
    wdata     = '0;
    wmask     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wd[i]  = 32'h0;
      wm[i]  = 4'h0;
      gap[i] = 0;
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_s), 64'd1);
    check("rst_w_ready", 64'(wr_s), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // Full-word write then read back
    wd[0] = 32'hDEAD_BEEF; wm[0] = 4'hF;
    write_burst(BASE, 3'd0);
    read_burst(BASE, 3'd0, 16'hFFFF, 1);

    // Partial byte mask merges into the existing word
    wd[0] = 32'h1122_3344; wm[0] = 4'b0101;
    write_burst(BASE, 3'd0);
    read_burst(BASE, 3'd0, 16'hFFFF, 1);

    // Four-beat read with back-pressure 1,0,0,1,1,0,1
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hA000_0000 + 32'(i * 32'h0101_0101);
      wm[i] = 4'hF;
    end
    write_burst(BASE, 3'd3);
    read_burst(BASE, 3'd3, 16'b1011001, 7);

    // Burst crossing the end of the range; misaligned single read
    wd[0] = 32'hCAFE_F00D; wm[0] = 4'hF;
    write_burst(BASE + 32'(4 * (DEPTH - 1)), 3'd0);
    read_burst(BASE + 32'(4 * (DEPTH - 1)), 3'd1, 16'hFFFF, 1);
    read_burst(BASE + 32'd2, 3'd0, 16'hFFFF, 1);

    // Write with w_valid gaps, beats 1..2 out of range
    wd[0] = 32'h1234_5678; wm[0] = 4'hF; gap[0] = 1;
    wd[1] = 32'h5555_5555; wm[1] = 4'hF; gap[1] = 2;
    wd[2] = 32'h6666_6666; wm[2] = 4'hF; gap[2] = 0;
    write_burst(BASE + 32'(4 * (DEPTH - 1)), 3'd2);
    read_burst(BASE + 32'(4 * (DEPTH - 1)), 3'd0, 16'hFFFF, 1);
    gap[0] = 0; gap[1] = 0;

    // Write starting just below the base: beat0 out, beat1 lands in word 0
    wd[0] = 32'h7777_7777; wm[0] = 4'hF;
    wd[1] = 32'h0BAD_C0DE; wm[1] = 4'b1100;
    write_burst(BASE - 32'd4, 3'd1);
    read_burst(BASE, 3'd1, 16'hFFFF, 1);

    // w_valid while idle is ignored
    wdata = 32'hFFFF_FFFF; wmask = 4'hF; w_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_w_ready", 64'(wr_s), 64'd0);
    end
    w_valid = 1'b0;
    read_burst(BASE, 3'd0, 16'hFFFF, 1);

    // Reset during beat 2 of an eight-beat read
    for (int i = 0; i < 8; i++) begin
      wd[i] = 32'hC000_0000 + 32'(i * 32'h0011_0011);
      wm[i] = 4'hF;
    end
    write_burst(BASE, 3'd7);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, model_mem[i]});
    send_cmd(BASE, 1'b1, 3'd7);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      check($sformatf("rst_burst_beat%0d_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("rst_burst_beat%0d_rdata", i), 64'(rsp_rdata), 64'(e[DW-1:0]));
      if (i < 2) @(negedge clk);
    end
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_rsp_err", 64'(rsp_err), 64'd0);
    check("midrst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    exp_q.delete();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("postrst_cmd_ready", 64'(cmd_s), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("postrst_no_stale", 64'(rsp_valid), 64'd0);
    end
    rsp_ready = 1'b0;

    // Normal operation resumes after reset
    wd[0] = 32'h0F0F_A5A5; wm[0] = 4'hF;
    write_burst(BASE + 32'd8, 3'd0);
    read_burst(BASE + 32'd8, 3'd0, 16'hFFFF, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
